gs232c_ras_ctrl: RTL and testbench

GS232C_RAS_CTRL -- requirements
Module: gs232c_ras_ctrl

---
 rtl/gs232c_ras_ctrl.sv | 118 +++++++++++
 tb/tb_gs232c_ras_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gs232c_ras_ctrl.sv
// Return-address-stack control: sequences the 16-entry RAM clear after reset,
// then arbitrates predict/branch/writeback push-pop strobes with flush priority
// and tracks the committed stack depth.
module gs232c_ras_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        pr_call_i,
  input  logic        pr_ret_i,
  input  logic [29:0] pr_link_pc_i,
  input  logic        br_call_i,
  input  logic        br_ret_i,
  input  logic        br_mispred_i,
  input  logic [29:0] br_link_pc_i,
  input  logic        wb_call_i,
  input  logic        wb_ret_i,
  input  logic        wb_flush_i,
  input  logic [29:0] wb_link_pc_i,
  output logic        raminit_valid,
  output logic        pr_link,
  output logic        pr_jrra,
  output logic        br_cancel,
  output logic        br_link,
  output logic        br_jrra,
  output logic        wb_cancel,
  output logic        wb_link,
  output logic        wb_jrra,
  output logic [29:0] pr_link_pc,
  output logic [29:0] br_link_pc,
  output logic [29:0] wb_link_pc,
  output logic        ras_ready,
  output logic        ra_valid,
  output logic        wb_underflow,
  output logic [4:0]  wb_depth
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_RECOV = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_init_cnt;
  logic [4:0]  r_depth;
  logic        r_underflow;

  logic        w_ready;
  logic        w_run;
  logic        w_wb_cancel;
  logic        w_br_cancel;
  logic        w_any_cancel;

  // Strobe decode; reset is folded in so nothing fires while the state is stale
  always_comb begin
    w_ready      = !reset && (r_state != S_INIT);
    w_run        = !reset && (r_state == S_RUN);
    w_wb_cancel  = wb_flush_i && w_ready;
    w_br_cancel  = br_mispred_i && w_ready && !wb_flush_i;
    w_any_cancel = w_wb_cancel || w_br_cancel;

    raminit_valid = !reset && (r_state == S_INIT);
    ras_ready     = w_ready;
    ra_valid      = w_run && !w_any_cancel;

    wb_cancel = w_wb_cancel;
    br_cancel = w_br_cancel;

    wb_link = wb_call_i && w_ready;
    wb_jrra = wb_ret_i && !wb_call_i && w_ready;

    br_link = br_call_i && w_ready && !w_wb_cancel;
    br_jrra = br_ret_i && !br_call_i && w_ready && !w_wb_cancel;

    pr_link = pr_call_i && w_run && !w_any_cancel;
    pr_jrra = pr_ret_i && !pr_call_i && w_run && !w_any_cancel;

    pr_link_pc = pr_link_pc_i;
    br_link_pc = br_link_pc_i;
    wb_link_pc = wb_link_pc_i;

    wb_depth     = r_depth;
    wb_underflow = r_underflow;
  end

  // Init sweep / run / one-cycle recovery state machine
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_cnt <= r_init_cnt + 4'd1;
          if (r_init_cnt == 4'd15) r_state <= S_RUN;
        end
        S_RUN:   if (w_any_cancel) r_state <= S_RECOV;
        S_RECOV: if (!w_any_cancel) r_state <= S_RUN;
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Committed depth counter (saturating both ends) and sticky underflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_depth     <= '0;
      r_underflow <= 1'b0;
    end else if (w_ready) begin
      if (wb_jrra && (r_depth == 5'd0)) r_underflow <= 1'b1;
      if (wb_call_i && !wb_ret_i) begin
        if (r_depth != 5'd16) r_depth <= r_depth + 5'd1;
      end else if (wb_ret_i && !wb_call_i) begin
        if (r_depth != 5'd0) r_depth <= r_depth - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_gs232c_ras_ctrl.sv
// Self-checking bench for gs232c_ras_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a cycle-count based model.
module tb_gs232c_ras_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pr_call_i = 0, pr_ret_i = 0;
  logic [29:0] pr_link_pc_i = '0;
  logic        br_call_i = 0, br_ret_i = 0, br_mispred_i = 0;
  logic [29:0] br_link_pc_i = '0;
  logic        wb_call_i = 0, wb_ret_i = 0, wb_flush_i = 0;
  logic [29:0] wb_link_pc_i = '0;

  logic        raminit_valid, pr_link, pr_jrra, br_cancel, br_link, br_jrra;
  logic        wb_cancel, wb_link, wb_jrra, ras_ready, ra_valid, wb_underflow;
  logic [29:0] pr_link_pc, br_link_pc, wb_link_pc;
  logic [4:0]  wb_depth;

  gs232c_ras_ctrl dut (
    .clock(clock), .reset(reset),
    .pr_call_i(pr_call_i), .pr_ret_i(pr_ret_i), .pr_link_pc_i(pr_link_pc_i),
    .br_call_i(br_call_i), .br_ret_i(br_ret_i), .br_mispred_i(br_mispred_i),
    .br_link_pc_i(br_link_pc_i),
    .wb_call_i(wb_call_i), .wb_ret_i(wb_ret_i), .wb_flush_i(wb_flush_i),
    .wb_link_pc_i(wb_link_pc_i),
    .raminit_valid(raminit_valid), .pr_link(pr_link), .pr_jrra(pr_jrra),
    .br_cancel(br_cancel), .br_link(br_link), .br_jrra(br_jrra),
    .wb_cancel(wb_cancel), .wb_link(wb_link), .wb_jrra(wb_jrra),
    .pr_link_pc(pr_link_pc), .br_link_pc(br_link_pc), .wb_link_pc(wb_link_pc),
    .ras_ready(ras_ready), .ra_valid(ra_valid), .wb_underflow(wb_underflow),
    .wb_depth(wb_depth)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: cycles elapsed since reset release, whether last cycle cancelled,
  // committed depth and sticky underflow.
  int m_post   = 0;
  bit m_prevc  = 0;
  int m_depth  = 0;
  bit m_uflow  = 0;
  bit m_valid  = 0;

  task automatic clr();
    pr_call_i = 0; pr_ret_i = 0;
    br_call_i = 0; br_ret_i = 0; br_mispred_i = 0;
    wb_call_i = 0; wb_ret_i = 0; wb_flush_i = 0;
  endtask

  task automatic check(input string tag);
    logic [10:0] exp_s, act_s;
    bit in_init, ready, run, wbc, brc, cxl;
    if (reset) begin
      exp_s = '0;
    end else begin
      in_init = (m_post < 16);
      ready   = !in_init;
      run     = ready && !m_prevc;
      wbc     = wb_flush_i && ready;
      brc     = br_mispred_i && ready && !wb_flush_i;
      cxl     = wbc || brc;
      exp_s = {in_init,
               pr_call_i && run && !cxl,
               pr_ret_i && !pr_call_i && run && !cxl,
               brc,
               br_call_i && ready && !wbc,
               br_ret_i && !br_call_i && ready && !wbc,
               wbc,
               wb_call_i && ready,
               wb_ret_i && !wb_call_i && ready,
               ready,
               run && !cxl};
    end
    act_s = {raminit_valid, pr_link, pr_jrra, br_cancel, br_link, br_jrra,
             wb_cancel, wb_link, wb_jrra, ras_ready, ra_valid};
    tests++;
    assert (act_s === exp_s) else begin
      fails++;
      $error("FAIL %s strobes: observed %b expected %b (post=%0d)", tag, act_s, exp_s, m_post);
    end
    tests++;
    assert ({pr_link_pc, br_link_pc, wb_link_pc} === {pr_link_pc_i, br_link_pc_i, wb_link_pc_i}) else begin
      fails++;
      $error("FAIL %s link_pc: observed %h/%h/%h expected %h/%h/%h", tag,
             pr_link_pc, br_link_pc, wb_link_pc, pr_link_pc_i, br_link_pc_i, wb_link_pc_i);
    end
    if (m_valid) begin
      tests++;
      assert ({wb_underflow, wb_depth} === {m_uflow, 5'(m_depth)}) else begin
        fails++;
        $error("FAIL %s depth: observed uf=%b d=%0d expected uf=%b d=%0d", tag,
               wb_underflow, wb_depth, m_uflow, m_depth);
      end
    end
  endtask

  task automatic model_update();
    bit ready, wbc, brc;
    if (reset) begin
      m_post = 0; m_prevc = 0; m_depth = 0; m_uflow = 0; m_valid = 1;
    end else begin
      ready = (m_post >= 16);
      wbc   = wb_flush_i && ready;
      brc   = br_mispred_i && ready && !wb_flush_i;
      if (!ready) m_post++;
      if (ready) begin
        if (wb_ret_i && !wb_call_i && m_depth == 0) m_uflow = 1;
        if (wb_call_i && !wb_ret_i) m_depth = (m_depth < 16) ? m_depth + 1 : 16;
        else if (wb_ret_i && !wb_call_i && m_depth > 0) m_depth = m_depth - 1;
      end
      m_prevc = ready && (wbc || brc);
    end
  endtask

  // One clock cycle: fresh link addresses, compare, advance model and DUT
  task automatic step(input string tag);
    pr_link_pc_i = 30'($urandom);
    br_link_pc_i = 30'($urandom);
    wb_link_pc_i = 30'($urandom);
    #1;
    check(tag);
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_val(input string tag, input int act, input int exp_v);
    tests++;
    assert (act === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp_v);
    end
  endtask

  initial begin
    clr();
    @(posedge clock);
    #1;
    // Reset held for a few cycles
    reset = 1;
    repeat (3) step("reset");

    // Init sweep with a call held high the whole time
    reset = 0;
    pr_call_i = 1;
    repeat (16) step("init");
    chk_val("first_run_ready", int'(ras_ready), 1);
    step("first_run");
    clr();
    step("idle");

    // Simultaneous call and return on every stage
    pr_call_i = 1; pr_ret_i = 1; br_call_i = 1; br_ret_i = 1; wb_call_i = 1; wb_ret_i = 1;
    step("call_ret_same");
    clr();
    step("idle2");

    // Flush + mispredict + predict call together, then recovery
    pr_call_i = 1; br_mispred_i = 1; wb_flush_i = 1;
    step("both_cancel");
    br_mispred_i = 0; wb_flush_i = 0;
    step("recov");
    step("back_to_run");
    clr();

    // Depth saturation, drain, and underflow
    wb_call_i = 1;
    repeat (17) step("push");
    chk_val("depth_sat", int'(wb_depth), 16);
    clr(); wb_ret_i = 1;
    repeat (16) step("pop");
    chk_val("depth_empty", int'(wb_depth), 0);
    step("pop_under");
    clr();
    chk_val("underflow_set", int'(wb_underflow), 1);
    wb_call_i = 1;
    repeat (3) step("push_after_uf");
    clr();
    chk_val("underflow_sticky", int'(wb_underflow), 1);

    // Back-to-back mispredicts stretch recovery
    br_mispred_i = 1; br_call_i = 1;
    repeat (2) step("mispred_b2b");
    clr();
    chk_val("recov_ext_ra", int'(ra_valid), 0);
    repeat (3) step("after_b2b");

    // Reset landing mid-init, then a complete fresh sweep
    reset = 1;
    step("reset2");
    reset = 0;
    repeat (8) step("init_part");
    reset = 1;
    step("reset_at_7");
    reset = 0;
    pr_ret_i = 1;
    repeat (18) step("init_again");
    clr();

    // Randomized traffic with occasional flush/mispredict/reset
    for (int i = 0; i < 600; i++) begin
      pr_call_i    = 1'($urandom);
      pr_ret_i     = 1'($urandom);
      br_call_i    = 1'($urandom);
      br_ret_i     = 1'($urandom);
      br_mispred_i = ($urandom_range(0, 7) == 0);
      wb_call_i    = ($urandom_range(0, 2) == 0);
      wb_ret_i     = ($urandom_range(0, 2) == 0);
      wb_flush_i   = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 149) == 0);
      step("random");
    end
    reset = 0;
    clr();
    step("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
